// File: rtl/mac_pkg.sv
// ============================================================================
//  mac_pkg
//  Shared FSM state type, accumulator width helper and default constants
//  for the controlador_mac multiply-accumulate sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      ACCUM  = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int TIMEOUT_DEF = 64;

   // Headroom of log2(terms) bits keeps a full group of extreme products from overflowing.
   function automatic int acc_width(input int num_bits, input int num_terms);
      return 2 * num_bits + $clog2(num_terms);
   endfunction

endpackage

`default_nettype wire

// File: rtl/detector_flanco.sv
// ============================================================================
//  detector_flanco
//  Rising-edge detector: registers the previous level every cycle.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module detector_flanco (
   input  logic clk,
   input  logic reset,
   input  logic nivel_i,
   output logic flanco_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= nivel_i;
      end
   end

   assign flanco_o = nivel_i & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/controlador_mac.sv
// ============================================================================
//  controlador_mac
//  Feeds operand pairs to a sequential multiplier, accumulates NUM_TERMS
//  signed products and presents the dot product over valid/ready.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module controlador_mac
   import mac_pkg::*;
#(
   parameter int NUM_BITS  = 3,
   parameter int NUM_TERMS = 4,
   parameter int ACC_BITS  = acc_width(NUM_BITS, NUM_TERMS),
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [NUM_BITS-1:0]   in_a,
   input  logic signed [NUM_BITS-1:0]   in_b,
   output logic signed [NUM_BITS-1:0]   mult_multiplicando,
   output logic signed [NUM_BITS-1:0]   mult_multiplicador,
   output logic                         mult_start,
   input  logic signed [2*NUM_BITS-1:0] mult_resultado,
   input  logic                         mult_fin,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_BITS-1:0]   out_suma,
   output logic                         err
);

   localparam int PROD_BITS = 2 * NUM_BITS;
   localparam int CNT_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
   localparam int WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  LAST_TERM = CNT_W'(NUM_TERMS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t                       state_q, state_d;
   logic signed [NUM_BITS-1:0]   op_a_q, op_a_d;
   logic signed [NUM_BITS-1:0]   op_b_q, op_b_d;
   logic signed [PROD_BITS-1:0]  prod_q, prod_d;
   logic signed [ACC_BITS-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [WAIT_W-1:0]            wait_q, wait_d;
   logic                         err_q, err_d;
   logic                         start_q, start_d;
   logic                         valid_q, valid_d;
   logic signed [ACC_BITS-1:0]   suma_q, suma_d;
   logic                         fin_edge;
   logic signed [ACC_BITS-1:0]   prod_ext;

   detector_flanco u_detector_flanco (
      .clk      (clk),
      .reset    (reset),
      .nivel_i  (mult_fin),
      .flanco_o (fin_edge)
   );

   // Signed cast sign-extends, so MIN*MIN stays a positive addend.
   assign prod_ext = ACC_BITS'(prod_q);

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      prod_d  = prod_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_a_d  = in_a;
               op_b_d  = in_b;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (fin_edge) begin
               prod_d  = mult_resultado;
               state_d = ACCUM;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ACCUM: begin
            acc_d = acc_q + prod_ext;
            if (cnt_q == LAST_TERM) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         DONE: begin
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      start_d = (state_d == LAUNCH);
      valid_d = (state_d == DONE);
      suma_d  = valid_d ? acc_d : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         prod_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         suma_q  <= '0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         start_q <= start_d;
         valid_q <= valid_d;
         suma_q  <= suma_d;
      end
   end

   assign in_ready           = (state_q == IDLE) & ~reset;
   assign mult_multiplicando = op_a_q;
   assign mult_multiplicador = op_b_q;
   assign mult_start         = start_q;
   assign out_valid          = valid_q;
   assign out_suma           = suma_q;
   assign err                = err_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_mac.sv
// ============================================================================
//  tb_controlador_mac
//  Self-checking bench with a behavioural multiplier and dot-product model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controlador_mac;

   localparam int NB = 3;
   localparam int NT = 4;
   localparam int AB = 8;
   localparam int TO = 64;

   logic                 clk       = 1'b0;
   logic                 reset     = 1'b1;
   logic                 in_valid  = 1'b0;
   logic                 in_ready;
   logic signed [NB-1:0] in_a      = '0;
   logic signed [NB-1:0] in_b      = '0;
   logic signed [NB-1:0] m_a;
   logic signed [NB-1:0] m_b;
   logic                 m_start;
   logic signed [2*NB-1:0] m_res   = '0;
   logic                 m_fin     = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [AB-1:0] out_suma;
   logic                 err;

   int checks = 0;
   int errors = 0;

   bit                     no_fin = 1'b0;
   int                     cd     = 0;
   logic signed [2*NB-1:0] pend   = '0;
   int                     start_pulses = 0;
   int                     wide_pulses  = 0;
   logic                   start_prev   = 1'b0;

   always #5 clk = ~clk;

   controlador_mac #(
      .NUM_BITS  (NB),
      .NUM_TERMS (NT),
      .TIMEOUT   (TO)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_a               (in_a),
      .in_b               (in_b),
      .mult_multiplicando (m_a),
      .mult_multiplicador (m_b),
      .mult_start         (m_start),
      .mult_resultado     (m_res),
      .mult_fin           (m_fin),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_suma           (out_suma),
      .err                (err)
   );

   // Multiplier model: Fin drops on start, rises 3..8 cycles later with the product.
   always @(posedge clk) begin
      if (m_start === 1'b1) begin
         m_fin <= 1'b0;
         pend  <= m_a * m_b;
         cd    <= no_fin ? 0 : int'($urandom_range(3, 8));
      end else if (cd > 1) begin
         cd <= cd - 1;
      end else if (cd == 1) begin
         cd    <= 0;
         m_fin <= 1'b1;
         m_res <= pend;
      end
   end

   always @(posedge clk) begin
      if (m_start === 1'b1) begin
         if (start_prev) wide_pulses <= wide_pulses + 1;
         else            start_pulses <= start_pulses + 1;
      end
      start_prev <= (m_start === 1'b1);
   end

   function automatic int ref_dot(input int a[NT], input int b[NT]);
      int s = 0;
      for (int i = 0; i < NT; i++) s += a[i] * b[i];
      return s;
   endfunction

   task automatic send_pair(input int a, input int b, output bit ok);
      ok = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         in_valid = 1'b1;
         in_a     = NB'(a);
         in_b     = NB'(b);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_group(input int a[NT], input int b[NT], output bit ok,
                            output logic signed [AB-1:0] sum);
      bit k;
      ok = 1'b1;
      for (int i = 0; i < NT; i++) begin
         send_pair(a[i], b[i], k);
         ok &= k;
      end
      wait_valid(k);
      ok &= k;
      sum = out_suma;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic rand_ops(output int a[NT], output int b[NT]);
      for (int i = 0; i < NT; i++) begin
         a[i] = int'($urandom_range(0, 7)) - 4;
         b[i] = int'($urandom_range(0, 7)) - 4;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got=%b exp=0", in_ready);
      end
      checks++;
      if ({m_start, out_valid, err} !== 3'b000 || out_suma !== '0) begin
         errors++;
         $display("FAIL reset_outputs got start=%b valid=%b err=%b suma=%0d exp all 0",
                  m_start, out_valid, err, out_suma);
      end
      checks++;
      if (m_a !== '0 || m_b !== '0) begin
         errors++;
         $display("FAIL reset_operands got a=%0d b=%0d exp 0 0", m_a, m_b);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_in_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_mixed();
      int a[NT] = '{-4, 3, -4, 1};
      int b[NT] = '{-4, 3, 3, -1};
      int sp0 = start_pulses;
      int wp0 = wide_pulses;
      bit ok;
      logic signed [AB-1:0] s;
      run_group(a, b, ok, s);
      checks++;
      if (!ok || s !== AB'(ref_dot(a, b))) begin
         errors++;
         $display("FAIL mixed_sum got=%0d ok=%b exp=%0d", s, ok, ref_dot(a, b));
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mixed_valid_drop got=%b exp=0", out_valid);
      end
      checks++;
      if (start_pulses - sp0 != NT || wide_pulses != wp0) begin
         errors++;
         $display("FAIL mixed_start_pulses got=%0d wide=%0d exp=%0d wide=0",
                  start_pulses - sp0, wide_pulses - wp0, NT);
      end
   endtask

   task automatic test_extremes();
      int a[NT] = '{-4, -4, -4, -4};
      int b[NT] = '{-4, -4, -4, -4};
      bit ok;
      logic signed [AB-1:0] s;
      run_group(a, b, ok, s);
      checks++;
      if (!ok || s !== 8'sh40) begin
         errors++;
         $display("FAIL min_min_sum got=%0d ok=%b exp=64", s, ok);
      end
      b = '{3, 3, 3, 3};
      run_group(a, b, ok, s);
      checks++;
      if (!ok || s !== 8'shD0) begin
         errors++;
         $display("FAIL neg_sum got=%0d ok=%b exp=-48", s, ok);
      end
   endtask

   task automatic test_random();
      int a[NT];
      int b[NT];
      bit ok;
      logic signed [AB-1:0] s;
      for (int g = 0; g < 6; g++) begin
         rand_ops(a, b);
         run_group(a, b, ok, s);
         checks++;
         if (!ok || s !== AB'(ref_dot(a, b))) begin
            errors++;
            $display("FAIL random_sum_%0d got=%0d ok=%b exp=%0d", g, s, ok, ref_dot(a, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      int a[NT];
      int b[NT];
      int a2[NT];
      int b2[NT];
      int sp0;
      bit ok;
      bit k;
      bit bad = 1'b0;
      logic signed [AB-1:0] s;
      rand_ops(a, b);
      rand_ops(a2, b2);
      for (int i = 0; i < NT; i++) begin
         send_pair(a[i], b[i], k);
         ok = (i == 0) ? k : (ok & k);
      end
      wait_valid(k);
      ok &= k;
      s = out_suma;
      sp0 = start_pulses;
      in_valid = 1'b1;
      in_a = NB'(a2[0]);
      in_b = NB'(b2[0]);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_suma !== s || in_ready !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (!ok || s !== AB'(ref_dot(a, b))) begin
         errors++;
         $display("FAIL hold_sum got=%0d ok=%b exp=%0d", s, ok, ref_dot(a, b));
      end
      checks++;
      if (bad || start_pulses != sp0) begin
         errors++;
         $display("FAIL hold_stable got unstable=%b new_starts=%0d exp 0 0",
                  bad, start_pulses - sp0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (m_start !== 1'b1) begin
         errors++;
         $display("FAIL accept_after_handshake got start=%b exp=1", m_start);
      end
      for (int i = 1; i < NT; i++) begin
         send_pair(a2[i], b2[i], k);
         ok &= k;
      end
      wait_valid(k);
      ok &= k;
      s = out_suma;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (!ok || s !== AB'(ref_dot(a2, b2))) begin
         errors++;
         $display("FAIL next_group_sum got=%0d ok=%b exp=%0d", s, ok, ref_dot(a2, b2));
      end
   endtask

   task automatic test_timeout();
      int a[NT];
      int b[NT];
      bit ok = 1'b0;
      bit early = 1'b0;
      logic signed [AB-1:0] s;
      no_fin = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b1;
      in_a = 3'sd2;
      in_b = 3'sd3;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (!ok || m_start !== 1'b1) begin
         errors++;
         $display("FAIL timeout_launch got start=%b ok=%b exp 1 1", m_start, ok);
      end
      for (int n = 1; n <= TO; n++) begin
         @(negedge clk);
         if (err !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL timeout_early got err=1 before %0d cycles exp=0", TO);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL timeout_flag got err=%b ready=%b exp 1 1", err, in_ready);
      end
      no_fin = 1'b0;
      rand_ops(a, b);
      run_group(a, b, ok, s);
      checks++;
      if (!ok || s !== AB'(ref_dot(a, b)) || err !== 1'b1) begin
         errors++;
         $display("FAIL after_timeout got sum=%0d err=%b ok=%b exp sum=%0d err=1",
                  s, err, ok, ref_dot(a, b));
      end
   endtask

   task automatic test_reset_midwait();
      int a[NT] = '{1, 1, 1, 1};
      int b[NT] = '{1, 1, 1, 1};
      bit ok;
      bit k;
      bit moved = 1'b0;
      logic signed [AB-1:0] s;
      send_pair(2, -3, ok);
      send_pair(-2, 3, k);
      ok &= k;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({m_start, out_valid, err} !== 3'b000 || out_suma !== '0 ||
          m_a !== '0 || m_b !== '0) begin
         errors++;
         $display("FAIL midwait_reset got start=%b valid=%b err=%b suma=%0d a=%0d b=%0d exp all 0",
                  m_start, out_valid, err, out_suma, m_a, m_b);
      end
      k = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_fin === 1'b1) begin
            k = 1'b1;
            break;
         end
         @(negedge clk);
      end
      ok &= k;
      for (int c = 0; c < 4; c++) begin
         if (in_ready !== 1'b1 || m_start !== 1'b0 || out_valid !== 1'b0) moved = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (!ok || moved) begin
         errors++;
         $display("FAIL late_fin_ignored got moved=%b ok=%b exp 0 1", moved, ok);
      end
      run_group(a, b, ok, s);
      checks++;
      if (!ok || s !== 8'sd4) begin
         errors++;
         $display("FAIL fresh_group got=%0d ok=%b exp=4", s, ok);
      end
   endtask

   initial begin
      test_reset();
      test_mixed();
      test_extremes();
      test_random();
      test_back_to_back();
      test_timeout();
      test_reset_midwait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
